hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//   Pipeline hazard controller for the 5-stage core. Keeps a shadow record
//   (rs1, rs2, rd, reg_write, mem_read, valid) for each instruction in EX, MEM
//   and WB. Drives the 2-bit selects of the EX-stage 3:1 operand muxes.
//   Generates load-use stall, branch flush and memory-wait freeze controls
//   for the IF/ID and ID/EX registers.
// PARAMETERS
//   REG_ADDR_W  5  width of register specifiers (x0..x31)
// PORTS
//   clk            in   1        core clock, rising edge
//   reset_n        in   1        asynchronous, active-low reset
//   id_valid       in   1        ID holds a real instruction
//   id_rs1         in   REG_ADDR_W  ID source 1
//   id_rs2         in   REG_ADDR_W  ID source 2
//   id_rd          in   REG_ADDR_W  ID destination
//   id_reg_write   in   1        ID instruction writes rd
//   id_mem_read    in   1        ID instruction is a load
//   ex_branch_taken in  1        EX resolved a taken branch/jump this cycle
//   mem_wait       in   1        data memory not ready; freeze pipeline
//   fwd_a_sel      out  2        EX operand A mux: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   fwd_b_sel      out  2        EX operand B mux, same encoding
//   stall_if_id    out  1        hold PC and IF/ID register
//   flush_if_id    out  1        clear IF/ID to bubble
//   bubble_ex      out  1        load bubble into ID/EX instead of ID instr
// BEHAVIOUR
//   - Stage records ex_r, mem_r, wb_r are flops.
//   - Async reset clears every record: valid=0, all fields 0.
//   - While reset_n=0, all outputs are 0; fwd selects are 2'b00.
//   - Advance rule, on each clk rising edge:
//       mem_wait=1: all records hold; no state change.
//       otherwise: wb_r<=mem_r, mem_r<=ex_r.
//         ex_r <= bubble (valid=0) if bubble_ex, else the ID fields.
//   - load_use = ex_r.valid & ex_r.mem_read & ex_r.rd!=0 & id_valid
//       & (id_rs1==ex_r.rd | id_rs2==ex_r.rd).
//   - Control outputs (combinational from records and inputs):
//       flush_if_id = ex_branch_taken & !mem_wait
//       bubble_ex   = (ex_branch_taken | load_use | !id_valid) & !mem_wait
//       stall_if_id = mem_wait | (load_use & !ex_branch_taken)
//   - Priority: mem_wait > ex_branch_taken > load_use.
//     A taken branch cancels a pending load-use stall, because the ID
//     instruction is discarded.
//   - Forwarding (operand A shown; B identical using rs2):
//       01 if mem_r.valid & mem_r.reg_write & mem_r.rd!=0 & mem_r.rd==ex_r.rs1
//       else 10 if the same test passes on wb_r
//       else 00
//     EX/MEM beats MEM/WB when both match (youngest value wins).
//   - A load in MEM never forwards to EX: load_use guarantees a one-cycle
//     gap, so the load reaches WB first and uses select 10.
//   - x0 is never forwarded. Bubbles (valid=0) never match.
//   - Latency: selects are valid in the same cycle the consumer sits in EX.
//     Stall/flush affect the next clock edge only.
//   - During mem_wait, selects stay consistent with the frozen records.
//   - Regfile write-before-read in ID is handled in the regfile, not here.
//   - Reset mid-operation discards all in-flight records immediately.
// TESTING
//   1. add x5 then add x6,x5,x1 back-to-back -> fwd_a_sel=01 in consumer EX cycle.
//   2. add x5; nop; sub x7,x2,x5 -> fwd_b_sel=10; with 2 nops -> 00.
//   3. lw x5 then add x6,x5,x5 -> stall_if_id=1, bubble_ex=1 for one cycle;
//      next cycle consumer in EX with fwd_a_sel=fwd_b_sel=10.
//   4. lw x5; consumer in ID; ex_branch_taken=1 in the same cycle
//      -> flush_if_id=1, bubble_ex=1, stall_if_id=0.
//   5. add x5 in MEM, mem_wait=1 for 3 cycles -> records frozen, fwd_a_sel
//      stays 01, stall_if_id=1 throughout, resumes cleanly after.
//   6. writes to x0, and reset_n low mid-stream -> selects 00; after reset
//      no forwarding to any old rd.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Hazard controller for the 5-stage core. It keeps a shadow record of the
//   instructions in EX, MEM and WB. From those records it drives the EX
//   operand forwarding selects. It also generates the load-use stall, the
//   branch flush and the memory-wait freeze controls for IF/ID and ID/EX.
// Ports
//   clk, reset_n                  core clock, async active-low reset
//   id_valid, id_rs1/rs2/rd       instruction currently in ID
//   id_reg_write, id_mem_read     ID instruction writes rd / is a load
//   ex_branch_taken               EX resolved a taken branch this cycle
//   mem_wait                      data memory busy, freeze the pipeline
//   fwd_a_sel, fwd_b_sel          00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_if_id, flush_if_id      hold / clear the IF/ID register
//   bubble_ex                     load a bubble into ID/EX
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_ex
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  valid;
  } stage_rec_t;

  localparam stage_rec_t REC_EMPTY = '0;

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d, mem_d, wb_d;
  stage_rec_t id_rec;

  logic load_use;
  logic bubble_int;

  // A record can supply a forwarded value only when it is a real instruction
  // that writes a nonzero register matching the requested source.
  function automatic logic rec_hits(input stage_rec_t r,
                                    input logic [REG_ADDR_W-1:0] src);
    return r.valid && r.reg_write && (r.rd != '0) && (r.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input stage_rec_t m,
                                         input stage_rec_t w,
                                         input logic [REG_ADDR_W-1:0] src);
    if (rec_hits(m, src))      return 2'b01;  // youngest producer wins
    else if (rec_hits(w, src)) return 2'b10;
    else                       return 2'b00;
  endfunction

  always_comb begin
    id_rec           = REC_EMPTY;
    id_rec.rs1       = id_rs1;
    id_rec.rs2       = id_rs2;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
    id_rec.valid     = 1'b1;

    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
               ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd));

    bubble_int = (ex_branch_taken || load_use || !id_valid) && !mem_wait;
  end

  // Record advance: everything freezes while memory is busy.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = bubble_int ? REC_EMPTY : id_rec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= REC_EMPTY;
      mem_q <= REC_EMPTY;
      wb_q  <= REC_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Outputs are forced low while reset is held, even though mem_wait or an
  // idle ID would otherwise raise stall or bubble.
  always_comb begin
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    bubble_ex   = 1'b0;
    if (reset_n) begin
      fwd_a_sel   = fwd_sel(mem_q, wb_q, ex_q.rs1);
      fwd_b_sel   = fwd_sel(mem_q, wb_q, ex_q.rs2);
      // A taken branch discards the ID instruction, so its load-use stall is moot.
      stall_if_id = mem_wait || (load_use && !ex_branch_taken);
      flush_if_id = ex_branch_taken && !mem_wait;
      bubble_ex   = bubble_int;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read;
  logic       ex_branch_taken, mem_wait;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if_id, flush_if_id, bubble_ex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .bubble_ex(bubble_ex)
  );

  // Reference model: the in-flight instructions as a queue.
  // Entry 0 is EX, entry 1 is MEM, and entry 2 is WB.
  typedef struct {
    int rs1, rs2, rd;
    bit wr, ld, real_ins;
  } ins_t;

  ins_t pipe[$];
  ins_t nop_ins;

  logic [1:0] obs_a, obs_b;
  logic       obs_stall, obs_flush, obs_bubble;
  bit         exp_bubble;

  function automatic int produces(ins_t p, int src);
    return (p.real_ins && p.wr && p.rd != 0 && p.rd == src) ? 1 : 0;
  endfunction

  function automatic logic [1:0] model_fwd(int src);
    if (produces(pipe[1], src) != 0) return 2'b01;
    if (produces(pipe[2], src) != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    pipe.delete();
    repeat (3) pipe.push_back(nop_ins);
  endtask

  // Drives one ID slot for one clock and checks every output against the model.
  task automatic cycle(input bit v, input int rs1, input int rs2, input int rd,
                       input bit wr, input bit ld, input bit br, input bit mw);
    bit lu;
    bit e_stall, e_flush;
    ins_t nxt;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0]; id_rd = rd[4:0];
    id_reg_write = wr; id_mem_read = ld; ex_branch_taken = br; mem_wait = mw;
    #1;
    lu = pipe[0].real_ins && pipe[0].ld && pipe[0].rd != 0 && v &&
         (rs1 == pipe[0].rd || rs2 == pipe[0].rd);
    e_stall = 0; e_flush = 0; exp_bubble = 0;
    if (mw) e_stall = 1;
    else if (br) begin e_flush = 1; exp_bubble = 1; end
    else if (lu) begin e_stall = 1; exp_bubble = 1; end
    else if (!v) exp_bubble = 1;
    obs_a = fwd_a_sel; obs_b = fwd_b_sel;
    obs_stall = stall_if_id; obs_flush = flush_if_id; obs_bubble = bubble_ex;
    chk("fwd_a", obs_a, model_fwd(pipe[0].rs1));
    chk("fwd_b", obs_b, model_fwd(pipe[0].rs2));
    chk("stall", {1'b0, obs_stall}, {1'b0, e_stall});
    chk("flush", {1'b0, obs_flush}, {1'b0, e_flush});
    chk("bubble", {1'b0, obs_bubble}, {1'b0, exp_bubble});
    @(posedge clk);
    if (!mw) begin
      nxt = nop_ins;
      if (!exp_bubble) begin
        nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.rd = rd;
        nxt.wr = wr; nxt.ld = ld; nxt.real_ins = 1;
      end
      void'(pipe.pop_back());
      pipe.push_front(nxt);
    end
  endtask

  task automatic nop_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    reset_n = 0; id_valid = 0; mem_wait = 1; ex_branch_taken = 1;
    #1;
    chk({tag, "_fwd_a"}, fwd_a_sel, 2'b00);
    chk({tag, "_fwd_b"}, fwd_b_sel, 2'b00);
    chk({tag, "_ctl"}, {1'b0, stall_if_id | flush_if_id | bubble_ex}, 2'b00);
    clear_model();
    @(negedge clk);
    reset_n = 1; mem_wait = 0; ex_branch_taken = 0;
  endtask

  initial begin
    nop_ins = '{rs1: 0, rs2: 0, rd: 0, wr: 0, ld: 0, real_ins: 0};
    clear_model();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0; mem_wait = 0;
    reset_n = 0;
    reset_check("reset");

    // add x5 ; add x6,x5,x1
    cycle(1, 1, 2, 5, 1, 0, 0, 0);
    cycle(1, 5, 1, 6, 1, 0, 0, 0);
    nop_cycle();
    chk("t1_fwd_a_exmem", obs_a, 2'b01);

    // add x5 ; nop ; sub x7,x2,x5
    cycle(1, 1, 2, 5, 1, 0, 0, 0);
    nop_cycle();
    cycle(1, 2, 5, 7, 1, 0, 0, 0);
    nop_cycle();
    chk("t2_fwd_b_memwb", obs_b, 2'b10);
    // with two nops the value comes from the regfile
    cycle(1, 1, 2, 5, 1, 0, 0, 0);
    nop_cycle();
    nop_cycle();
    cycle(1, 2, 5, 7, 1, 0, 0, 0);
    nop_cycle();
    chk("t2_fwd_b_regfile", obs_b, 2'b00);

    // lw x5 ; add x6,x5,x5
    cycle(1, 3, 0, 5, 1, 1, 0, 0);
    cycle(1, 5, 5, 6, 1, 0, 0, 0);
    chk("t3_stall", {1'b0, obs_stall}, 2'b01);
    chk("t3_bubble", {1'b0, obs_bubble}, 2'b01);
    cycle(1, 5, 5, 6, 1, 0, 0, 0);
    chk("t3_no_second_stall", {1'b0, obs_stall}, 2'b00);
    nop_cycle();
    chk("t3_fwd_a", obs_a, 2'b10);
    chk("t3_fwd_b", obs_b, 2'b10);

    // lw x5 ; consumer in ID with a taken branch
    cycle(1, 3, 0, 5, 1, 1, 0, 0);
    cycle(1, 5, 1, 6, 1, 0, 1, 0);
    chk("t4_flush", {1'b0, obs_flush}, 2'b01);
    chk("t4_bubble", {1'b0, obs_bubble}, 2'b01);
    chk("t4_stall", {1'b0, obs_stall}, 2'b00);
    nop_cycle();

    // add x5 in MEM with the consumer in EX, then memory wait for 3 cycles
    cycle(1, 1, 2, 5, 1, 0, 0, 0);
    cycle(1, 5, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4, 4, 8, 1, 0, 0, 1);
      chk("t5_frozen_fwd_a", obs_a, 2'b01);
      chk("t5_frozen_stall", {1'b0, obs_stall}, 2'b01);
    end
    cycle(1, 6, 0, 9, 1, 0, 0, 0);
    chk("t5_resume_fwd_a", obs_a, 2'b01);
    nop_cycle();
    chk("t5_resume_fwd_a_x6", obs_a, 2'b01);

    // writes to x0 are never forwarded
    cycle(1, 1, 2, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 6, 1, 0, 0, 0);
    nop_cycle();
    chk("t6_x0_a", obs_a, 2'b00);
    chk("t6_x0_b", obs_b, 2'b00);

    // reset in the middle of a stream drops in-flight producers
    cycle(1, 1, 2, 9, 1, 0, 0, 0);
    cycle(1, 1, 2, 10, 1, 0, 0, 0);
    reset_check("midreset");
    cycle(1, 9, 10, 11, 1, 0, 0, 0);
    nop_cycle();
    chk("t6_after_reset_a", obs_a, 2'b00);
    chk("t6_after_reset_b", obs_b, 2'b00);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      if (n == 200) reset_check("rand_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
